prv_trap_ctrl: RTL and testbench
================================

# prv_trap_ctrl

Privilege-side trap controller that terminates the hazard→priv exception/return protocol. Takes the exception flags, `ret`, `epc` and `badaddr` from the hazard unit, plus interrupt-pending lines. Picks one trap cause and waits for the pipeline to drain. Then commits mcause/mepc/mtval/mstatus updates to the CSR file and redirects fetch through `insert_pc`/`priv_pc`. Sits inside the priv block between the pipeline interface and the machine-mode CSR registers.

## Interface
Parameters:
- `XLEN`, 32, data/address width.
- `RMGMT_W`, 2, width of `ex_rmgmt_cause` (= clog2 of NUM_EXTENSIONS).

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env_m` in 1 each: exception flags from the hazard unit.
- `prot_fault_i, prot_fault_l, prot_fault_s` in 1 each: PMA/PMP faults. ORed with `fault_insn`, `fault_l` and `fault_s` respectively.
- `ex_rmgmt` in 1, `ex_rmgmt_cause` in RMGMT_W: RISC-MGMT extension exception and its cause.
- `ret` in 1: mret retiring.
- `pipe_clear` in 1: pipeline drained.
- `epc, badaddr` in XLEN: faulting PC and faulting address.
- `timer_int, soft_int, ext_int` in 1: pending interrupt levels.
- `mstatus_mie` in 1, `mie_mtie, mie_msie, mie_meie` in 1: interrupt enables.
- `mtvec, mepc_r` in XLEN: current CSR values.
- `insert_pc` out 1, `priv_pc` out XLEN: fetch redirect.
- `intr` out 1: interrupt trap in progress; tells hazard to flush.
- `mcause_wen` out 1, `mcause_val` out XLEN.
- `mepc_wen, mtval_wen` out 1, `mepc_val, mtval_val` out XLEN.
- `mstatus_trap, mstatus_ret` out 1: trap strobe performs MPIE←MIE, MIE←0; ret strobe performs MIE←MPIE, MPIE←1.

## Operation
- FSM states: IDLE, DRAIN, COMMIT, REDIRECT.
- **Trap event** in IDLE: any exception, OR `mstatus_mie` && (`ext_int`&`mie_meie` | `soft_int`&`mie_msie` | `timer_int`&`mie_mtie`).
  - On a trap event: latch cause, `epc` and tval, then go to DRAIN.
  - Otherwise, `ret` latches a return and goes to DRAIN.
- **Priority:**
  - Exceptions beat interrupts, and interrupts beat `ret`.
  - Exception order: breakpoint(3) > fault_insn(1) > illegal(2) > mal_insn(0) > env_m(11) > mal_s(6) > mal_l(4) > fault_s(7) > fault_l(5) > rmgmt(24+ex_rmgmt_cause).
  - Interrupt order: ext(11) > soft(3) > timer(7).
- **mcause_val:** bit XLEN-1 = interrupt; low bits = code.
- **mtval_val:**
  - `badaddr` for mal/fault insn/l/s.
  - 0 for all other causes.
- **DRAIN:** hold until `pipe_clear`=1, then go to COMMIT.
- **COMMIT** (exactly one cycle), then go to REDIRECT:
  - Trap: `mcause_wen`, `mepc_wen` (`mepc_val` = latched epc), `mtval_wen`, `mstatus_trap` all = 1.
  - Return: only `mstatus_ret` = 1.
- **REDIRECT** (one cycle), then go to IDLE:
  - `insert_pc` = 1.
  - `priv_pc` = {mtvec[XLEN-1:2],2'b00} for a trap, `mepc_r` for a return.
- **intr** = 1 in DRAIN and COMMIT when the latched event is an interrupt.
- **Events while not in IDLE:** not latched. Interrupts are level and re-evaluate in IDLE; the hazard unit holds exception flags until redirect.
- **Interrupt deasserting during DRAIN:** the trap is still taken with the latched cause.

## Timing
- Reset values: state = IDLE; all outputs 0, including `priv_pc` and `*_val`. Reset asserted mid-trap aborts to IDLE with no CSR strobe.
- Latency, event sampled in cycle 0 with `pipe_clear` already 1:
  - cycle 1: DRAIN
  - cycle 2: COMMIT strobes
  - cycle 3: `insert_pc`
  - cycle 4: IDLE, can accept a new event
- Each cycle of `pipe_clear`=0 adds one cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Configuration
- `PRV_VECTORED_INTR_EN` defined:
  - When mtvec[1:0]==2'b01 and the trap is an interrupt, `priv_pc` = base + 4×code.
  - Exceptions always use base.
- Undefined: mtvec[1:0] is ignored and all traps go to base.

## Structure
- In `machine_mode_types_1_12_pkg`:
  - `trap_state_t` enum.
  - Exception/interrupt cause code constants.
- Sub-module `prv_trap_prio`: combinational priority encoder producing {valid, is_intr, code, use_badaddr}.

## Test plan
- **Illegal instruction:** `illegal_insn`=1 with `epc`=0x100, `pipe_clear`=1, mtvec=0x8000.
  - cycle 2: mcause=2, mepc=0x100, mtval=0.
  - cycle 3: `insert_pc`=1, `priv_pc`=0x8000.
- **Simultaneous exception and interrupts:** `mal_l` with `badaddr`=0x203, plus `timer_int` enabled. Required: mcause=4, mtval=0x203, `intr`=0.
- **Interrupt during drain:** `ext_int` and `soft_int` enabled, `pipe_clear` low for 3 cycles.
  - `intr`=1 throughout DRAIN.
  - mcause=0x8000000B.
  - `insert_pc` in cycle 6.
- **Return:** `ret` with `mepc_r`=0x440. Required: `mstatus_ret`=1 in cycle 2, `priv_pc`=0x440 in cycle 3, no mcause_wen.
- **Vectored interrupt:** `PRV_VECTORED_INTR_EN`, mtvec=0x8001, `timer_int`. Required: `priv_pc`=0x801C. With the macro undefined: 0x8000.
- **Reset mid-trap:** `RST` asserted in COMMIT. Required: all outputs 0 immediately, state IDLE, no `insert_pc`.

Source files
------------

// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared types for the machine-mode trap controller: FSM states and
// exception/interrupt cause codes.
package machine_mode_types_1_12_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_state_t;

  localparam int CODE_W = 6;

  localparam logic [CODE_W-1:0] EXC_MAL_INSN   = 6'd0;
  localparam logic [CODE_W-1:0] EXC_FAULT_INSN = 6'd1;
  localparam logic [CODE_W-1:0] EXC_ILLEGAL    = 6'd2;
  localparam logic [CODE_W-1:0] EXC_BREAK      = 6'd3;
  localparam logic [CODE_W-1:0] EXC_MAL_L      = 6'd4;
  localparam logic [CODE_W-1:0] EXC_FAULT_L    = 6'd5;
  localparam logic [CODE_W-1:0] EXC_MAL_S      = 6'd6;
  localparam logic [CODE_W-1:0] EXC_FAULT_S    = 6'd7;
  localparam logic [CODE_W-1:0] EXC_ECALL_M    = 6'd11;
  localparam logic [CODE_W-1:0] EXC_RMGMT_BASE = 6'd24;

  localparam logic [CODE_W-1:0] INT_SOFT  = 6'd3;
  localparam logic [CODE_W-1:0] INT_TIMER = 6'd7;
  localparam logic [CODE_W-1:0] INT_EXT   = 6'd11;

endpackage

// File: rtl/prv_trap_prio.sv
// Combinational trap priority encoder: exceptions first in fixed order,
// then already-masked interrupts.
module prv_trap_prio
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int RMGMT_W = 2
) (
  input  logic               fault_insn,
  input  logic               mal_insn,
  input  logic               illegal_insn,
  input  logic               fault_l,
  input  logic               mal_l,
  input  logic               fault_s,
  input  logic               mal_s,
  input  logic               breakpoint,
  input  logic               env_m,
  input  logic               ex_rmgmt,
  input  logic [RMGMT_W-1:0] ex_rmgmt_cause,
  input  logic               irq_ext,
  input  logic               irq_soft,
  input  logic               irq_timer,
  output logic               valid,
  output logic               is_intr,
  output logic [CODE_W-1:0]  code,
  output logic               use_badaddr
);

  always_comb begin
    valid       = 1'b1;
    is_intr     = 1'b0;
    code        = '0;
    use_badaddr = 1'b0;
    if (breakpoint)        code = EXC_BREAK;
    else if (fault_insn) begin code = EXC_FAULT_INSN; use_badaddr = 1'b1; end
    else if (illegal_insn) code = EXC_ILLEGAL;
    else if (mal_insn)   begin code = EXC_MAL_INSN;   use_badaddr = 1'b1; end
    else if (env_m)        code = EXC_ECALL_M;
    else if (mal_s)      begin code = EXC_MAL_S;      use_badaddr = 1'b1; end
    else if (mal_l)      begin code = EXC_MAL_L;      use_badaddr = 1'b1; end
    else if (fault_s)    begin code = EXC_FAULT_S;    use_badaddr = 1'b1; end
    else if (fault_l)    begin code = EXC_FAULT_L;    use_badaddr = 1'b1; end
    else if (ex_rmgmt)     code = EXC_RMGMT_BASE + CODE_W'(ex_rmgmt_cause);
    else if (irq_ext)    begin code = INT_EXT;   is_intr = 1'b1; end
    else if (irq_soft)   begin code = INT_SOFT;  is_intr = 1'b1; end
    else if (irq_timer)  begin code = INT_TIMER; is_intr = 1'b1; end
    else                   valid = 1'b0;
  end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Machine-mode trap/return controller: latch cause, drain, commit CSRs, redirect.
// Optional PRV_VECTORED_INTR_EN: vectored interrupt targets when mtvec[1:0]==2'b01.
module prv_trap_ctrl
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RMGMT_W = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               fault_insn,
  input  logic               mal_insn,
  input  logic               illegal_insn,
  input  logic               fault_l,
  input  logic               mal_l,
  input  logic               fault_s,
  input  logic               mal_s,
  input  logic               breakpoint,
  input  logic               env_m,
  input  logic               prot_fault_i,
  input  logic               prot_fault_l,
  input  logic               prot_fault_s,
  input  logic               ex_rmgmt,
  input  logic [RMGMT_W-1:0] ex_rmgmt_cause,
  input  logic               ret,
  input  logic               pipe_clear,
  input  logic [XLEN-1:0]    epc,
  input  logic [XLEN-1:0]    badaddr,
  input  logic               timer_int,
  input  logic               soft_int,
  input  logic               ext_int,
  input  logic               mstatus_mie,
  input  logic               mie_mtie,
  input  logic               mie_msie,
  input  logic               mie_meie,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    mepc_r,
  output logic               insert_pc,
  output logic [XLEN-1:0]    priv_pc,
  output logic               intr,
  output logic               mcause_wen,
  output logic [XLEN-1:0]    mcause_val,
  output logic               mepc_wen,
  output logic               mtval_wen,
  output logic [XLEN-1:0]    mepc_val,
  output logic [XLEN-1:0]    mtval_val,
  output logic               mstatus_trap,
  output logic               mstatus_ret
);

  trap_state_t       r_state, w_state_next;
  logic              r_is_intr, r_is_ret;
  logic [CODE_W-1:0] r_code;
  logic [XLEN-1:0]   r_epc, r_tval, r_priv_pc, w_target, w_base;
  logic              w_valid, w_is_intr, w_use_badaddr;
  logic [CODE_W-1:0] w_code;

  prv_trap_prio #(.RMGMT_W(RMGMT_W)) u_prio (
    .fault_insn     (fault_insn | prot_fault_i),
    .mal_insn       (mal_insn),
    .illegal_insn   (illegal_insn),
    .fault_l        (fault_l | prot_fault_l),
    .mal_l          (mal_l),
    .fault_s        (fault_s | prot_fault_s),
    .mal_s          (mal_s),
    .breakpoint     (breakpoint),
    .env_m          (env_m),
    .ex_rmgmt       (ex_rmgmt),
    .ex_rmgmt_cause (ex_rmgmt_cause),
    .irq_ext        (mstatus_mie & ext_int & mie_meie),
    .irq_soft       (mstatus_mie & soft_int & mie_msie),
    .irq_timer      (mstatus_mie & timer_int & mie_mtie),
    .valid          (w_valid),
    .is_intr        (w_is_intr),
    .code           (w_code),
    .use_badaddr    (w_use_badaddr)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_valid || ret) w_state_next = ST_DRAIN;
      ST_DRAIN:    if (pipe_clear) w_state_next = ST_COMMIT;
      ST_COMMIT:   w_state_next = ST_REDIRECT;
      ST_REDIRECT: w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // Cause is captured only in IDLE; later input changes cannot alter the trap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_is_intr <= 1'b0;
      r_is_ret  <= 1'b0;
      r_code    <= '0;
      r_epc     <= '0;
      r_tval    <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_valid) begin
        r_is_intr <= w_is_intr;
        r_is_ret  <= 1'b0;
        r_code    <= w_code;
        r_epc     <= epc;
        r_tval    <= w_use_badaddr ? badaddr : '0;
      end else if (ret) begin
        r_is_intr <= 1'b0;
        r_is_ret  <= 1'b1;
      end
    end
  end

  assign w_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef PRV_VECTORED_INTR_EN
  always_comb begin
    w_target = w_base;
    if (r_is_ret) w_target = mepc_r;
    else if (r_is_intr && mtvec[1:0] == 2'b01) w_target = w_base + (XLEN'(r_code) << 2);
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = ^mtvec[1:0];
  assign w_target = r_is_ret ? mepc_r : w_base;
`endif

  // Target is sampled during COMMIT so priv_pc is a pure register in REDIRECT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_priv_pc <= '0;
    else     r_priv_pc <= (r_state == ST_COMMIT) ? w_target : '0;
  end

  assign insert_pc    = (r_state == ST_REDIRECT);
  assign priv_pc      = r_priv_pc;
  assign intr         = r_is_intr && (r_state == ST_DRAIN || r_state == ST_COMMIT);
  assign mcause_wen   = (r_state == ST_COMMIT) && !r_is_ret;
  assign mepc_wen     = mcause_wen;
  assign mtval_wen    = mcause_wen;
  assign mstatus_trap = mcause_wen;
  assign mstatus_ret  = (r_state == ST_COMMIT) && r_is_ret;
  assign mcause_val   = {r_is_intr, {(XLEN-1-CODE_W){1'b0}}, r_code};
  assign mepc_val     = r_epc;
  assign mtval_val    = r_tval;

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Directed bench for prv_trap_ctrl; expected values honour PRV_VECTORED_INTR_EN.
module tb_prv_trap_ctrl;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s;
  logic        breakpoint, env_m, prot_fault_i, prot_fault_l, prot_fault_s, ex_rmgmt;
  logic [1:0]  ex_rmgmt_cause;
  logic        ret, pipe_clear, timer_int, soft_int, ext_int;
  logic        mstatus_mie, mie_mtie, mie_msie, mie_meie;
  logic [31:0] epc, badaddr, mtvec, mepc_r;
  logic        insert_pc, intr, mcause_wen, mepc_wen, mtval_wen, mstatus_trap, mstatus_ret;
  logic [31:0] priv_pc, mcause_val, mepc_val, mtval_val;

  int n_pass = 0, n_total = 0, n_fail = 0;

  prv_trap_ctrl #(.XLEN(32), .RMGMT_W(2)) dut (
    .CLK(CLK), .RST(RST),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .fault_l(fault_l), .mal_l(mal_l), .fault_s(fault_s), .mal_s(mal_s),
    .breakpoint(breakpoint), .env_m(env_m),
    .prot_fault_i(prot_fault_i), .prot_fault_l(prot_fault_l), .prot_fault_s(prot_fault_s),
    .ex_rmgmt(ex_rmgmt), .ex_rmgmt_cause(ex_rmgmt_cause),
    .ret(ret), .pipe_clear(pipe_clear), .epc(epc), .badaddr(badaddr),
    .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
    .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie), .mie_msie(mie_msie), .mie_meie(mie_meie),
    .mtvec(mtvec), .mepc_r(mepc_r),
    .insert_pc(insert_pc), .priv_pc(priv_pc), .intr(intr),
    .mcause_wen(mcause_wen), .mcause_val(mcause_val),
    .mepc_wen(mepc_wen), .mtval_wen(mtval_wen), .mepc_val(mepc_val), .mtval_val(mtval_val),
    .mstatus_trap(mstatus_trap), .mstatus_ret(mstatus_ret)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %-14s obs=%h exp=%h", tag, obs, exp);
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_ev();
    {fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s} = '0;
    {breakpoint, env_m, prot_fault_i, prot_fault_l, prot_fault_s, ex_rmgmt} = '0;
    {ret, timer_int, soft_int, ext_int} = '0;
    ex_rmgmt_cause = '0;
  endtask

  // Strobe bundle: {insert_pc, intr, mcause_wen, mepc_wen, mtval_wen, mstatus_trap, mstatus_ret}
  function automatic logic [31:0] strobes();
    return {25'd0, insert_pc, intr, mcause_wen, mepc_wen, mtval_wen, mstatus_trap, mstatus_ret};
  endfunction

  // Exception with pipe_clear=1: checks commit in cycle 2 and redirect in cycle 3.
  task automatic exc_seq(input string tag, input logic [31:0] cause, input logic [31:0] tval,
                         input logic [31:0] pc_exp);
    step();
    chk({tag, "_c1"}, strobes(), 32'h0);
    step();
    chk({tag, "_cause"}, mcause_val, cause);
    chk({tag, "_tval"}, mtval_val, tval);
    chk({tag, "_c2"}, strobes(), 32'h1E);
    step();
    clr_ev();
    chk({tag, "_c3"}, strobes(), 32'h40);
    chk({tag, "_pc"}, priv_pc, pc_exp);
    step();
    chk({tag, "_c4"}, strobes(), 32'h0);
  endtask

  logic [31:0] exp_vec_t, exp_vec_e;

  initial begin
    clr_ev();
    pipe_clear = 1'b1;
    epc = 32'h0; badaddr = 32'h0; mtvec = 32'h8000; mepc_r = 32'h0;
    mstatus_mie = 1'b1; mie_mtie = 1'b1; mie_msie = 1'b1; mie_meie = 1'b1;
`ifdef PRV_VECTORED_INTR_EN
    exp_vec_t = 32'h801C; exp_vec_e = 32'h8000;
`else
    exp_vec_t = 32'h8000; exp_vec_e = 32'h8000;
`endif
    #2;
    chk("rst_strobes", strobes(), 32'h0);
    chk("rst_priv_pc", priv_pc, 32'h0);
    chk("rst_vals", mcause_val | mepc_val | mtval_val, 32'h0);
    step(); step();
    RST = 1'b0;
    step();

    // Illegal instruction
    illegal_insn = 1'b1; epc = 32'h100; badaddr = 32'hDEAD;
    exc_seq("illegal", 32'd2, 32'h0, 32'h8000);
    chk("illegal_mepc", mepc_val, 32'h100);

    // Misaligned load beats an enabled timer interrupt
    mal_l = 1'b1; badaddr = 32'h203; timer_int = 1'b1; epc = 32'h200;
    exc_seq("mal_l", 32'd4, 32'h203, 32'h8000);

    // Breakpoint beats fault_l, tval stays 0
    breakpoint = 1'b1; fault_l = 1'b1; badaddr = 32'h77;
    exc_seq("bkpt", 32'd3, 32'h0, 32'h8000);

    // PMP store fault reports badaddr
    prot_fault_s = 1'b1; badaddr = 32'h55;
    exc_seq("prot_s", 32'd7, 32'h55, 32'h8000);

    // RISC-MGMT cause offset
    ex_rmgmt = 1'b1; ex_rmgmt_cause = 2'd2;
    exc_seq("rmgmt", 32'd26, 32'h0, 32'h8000);

    // Ext + soft interrupt, drain held 3 cycles, lines drop during drain
    ext_int = 1'b1; soft_int = 1'b1; pipe_clear = 1'b0; epc = 32'h300;
    step();
    ext_int = 1'b0; soft_int = 1'b0;
    chk("irq_c1", strobes(), 32'h20);
    step();
    chk("irq_c2", strobes(), 32'h20);
    step();
    chk("irq_c3", strobes(), 32'h20);
    step();
    chk("irq_c4", strobes(), 32'h20);
    pipe_clear = 1'b1;
    step();
    chk("irq_c5", strobes(), 32'h3E);
    chk("irq_cause", mcause_val, 32'h8000000B);
    chk("irq_mepc", mepc_val, 32'h300);
    chk("irq_tval", mtval_val, 32'h0);
    step();
    chk("irq_c6", strobes(), 32'h40);
    chk("irq_pc", priv_pc, 32'h8000);
    step();

    // Return
    ret = 1'b1; mepc_r = 32'h440;
    step();
    clr_ev();
    chk("ret_c1", strobes(), 32'h0);
    step();
    chk("ret_c2", strobes(), 32'h01);
    step();
    chk("ret_c3", strobes(), 32'h40);
    chk("ret_pc", priv_pc, 32'h440);
    step();
    chk("ret_c4", strobes(), 32'h0);

    // Vectored timer interrupt, then an exception under the same mtvec
    mtvec = 32'h8001; timer_int = 1'b1;
    step();
    clr_ev();
    chk("vec_c1", strobes(), 32'h20);
    step();
    chk("vec_cause", mcause_val, 32'h80000007);
    step();
    chk("vec_pc", priv_pc, exp_vec_t);
    step();
    env_m = 1'b1; epc = 32'h500;
    exc_seq("ecall", 32'd11, 32'h0, exp_vec_e);

    // Interrupt beats ret
    mtvec = 32'h8000; ret = 1'b1; soft_int = 1'b1;
    step();
    clr_ev();
    step();
    chk("irq_ret_c2", strobes(), 32'h3E);
    chk("irq_ret_cause", mcause_val, 32'h80000003);
    step(); step();

    // Reset asserted during COMMIT
    illegal_insn = 1'b1; epc = 32'h900;
    step(); step();
    chk("rstm_commit", strobes(), 32'h1E);
    #1 RST = 1'b1;
    #1;
    chk("rstm_strobes", strobes(), 32'h0);
    chk("rstm_vals", mcause_val | mepc_val | mtval_val | priv_pc, 32'h0);
    clr_ev();
    step();
    RST = 1'b0;
    step();
    chk("rstm_after1", strobes(), 32'h0);
    step();
    chk("rstm_after2", {insert_pc, priv_pc[30:0]}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
